adder_arbiter: RTL and testbench
================================

Name: adder_arbiter

Overview:
- Controller that shares one N-bit ripple adder instance among NREQ requesters.
- Round-robin arbitration; latches the winner's operands into registers that drive the shared adder's inputs; captures the adder's sum/carry-out into a result register.
- Returns the result with a one-cycle done pulse tagged by a one-hot grant.
- Sits between datapath clients (ALU, address generators) and a single genericAdder.

Parameters:
- N, 32: operand/result width; must match the attached adder.
- NREQ, 4: number of requesters, 2..8.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  synchronous active-low reset
- req  input  NREQ  level request per requester; hold until served
- a_bus  input  NREQ*N  operand A per requester; slice i = bits [i*N+N-1 : i*N]
- b_bus  input  NREQ*N  operand B per requester, same packing
- cin_bus  input  NREQ  carry-in per requester
- grant  output  NREQ  one-hot owner of the current transaction; 0 when idle
- busy  output  1  high in ADD and DONE
- done  output  1  one-cycle pulse; sum/cout valid for the requester in grant
- sum  output  N  registered result
- cout  output  1  registered carry-out
- add_a  output  N  to shared adder input A (registered)
- add_b  output  N  to shared adder input B (registered)
- add_cin  output  1  to shared adder carry-in (registered)
- add_s  input  N  from shared adder sum
- add_cout  input  1  from shared adder carry-out

Behaviour:
- Reset (resetn=0 at a rising edge): state=IDLE; grant, done, busy, sum, cout, add_a, add_b, add_cin all 0; rr pointer ptr=NREQ-1, so requester 0 has first priority.
- Reset overrides everything, including mid-transaction; any in-flight result is discarded and no done is issued.
- States: IDLE, ADD, DONE.
- Arbitration (combinational over the eligible request vector):
  - Winner is the first set bit searching ptr+1, ptr+2, … modulo NREQ.
  - On the transition into ADD: ptr <= winner; grant <= onehot(winner); add_a/add_b/add_cin <= winner's slices.
- IDLE:
  - eligible = req.
  - If any bit set, go to ADD; else stay, with grant=0.
- ADD (one cycle; adder settles combinationally):
  - sum <= add_s; cout <= add_cout; done <= 1; next state DONE.
  - req changes during ADD are ignored.
- DONE:
  - done=1 for exactly this cycle; grant holds the owner.
  - eligible = req with the owner's bit masked.
  - If eligible is nonzero: arbitrate and go directly to ADD (back-to-back). Else go to IDLE.
  - done <= 0 in both cases.
- sum/cout hold their value until the next ADD capture.
- Latency: req sampled high in IDLE at edge k → ADD after edge k → done high after edge k+1.
- Throughput:
  - Under contention, one result every 2 cycles.
  - A lone continuously-asserted requester is served every 3 cycles (DONE masks it, IDLE re-arbitrates).
- Requester contract:
  - Operands must be stable from req assertion until grant is seen.
  - To avoid a repeat service, req must drop by the edge ending DONE.
- Arithmetic:
  - sum = (A + B + cin) mod 2^N; cout = bit N of the full sum.
  - The result comes exclusively from add_s/add_cout; the block contains no adder of its own.
- Requests with index ≥ NREQ do not exist; unused bus bits are ignored.

Optional Feature:
- Macro: ADDER_ARBITER_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit).
  - Registered in ADD as (add_a[N-1]==add_b[N-1]) && (add_s[N-1]!=add_a[N-1]).
  - Reset 0; held like sum.
- Undefined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Single request:
  - Stimulus: req=0001, A0=5, B0=7, cin0=0 held.
  - Response: grant=0001 one cycle after the sampling edge; done pulses one cycle later with sum=12, cout=0; done high exactly 1 cycle.
- Carry chain:
  - Stimulus: req=0100, A2=0xFFFFFFFF, B2=0x00000001, cin2=0.
  - Response: sum=0x00000000, cout=1, grant=0100 during done.
  - Variant: cin2=1 with B2=0 gives the same result.
- Full contention:
  - Stimulus: req=1111 held; Ai=i+1, Bi=10.
  - Response: done pulses every 2 cycles with grant order 0001, 0010, 0100, 1000, 0001; sums 11, 12, 13, 14, 11.
- Lone continuous requester:
  - Stimulus: req=0010 held.
  - Response: done every 3 cycles; state sequence ADD, DONE, IDLE repeating; grant=0 in IDLE.
- Reset mid-operation:
  - Stimulus: resetn=0 at the edge where state=ADD.
  - Response: next cycle done=0, grant=0, sum=0, busy=0; the first request after release goes to requester 0 when req=1111.
- Overflow (ADDER_ARBITER_OVF_EN defined):
  - Stimulus: A=0x7FFFFFFF, B=1.
  - Response: ovf=1, sum=0x80000000, cout=0.
  - Stimulus: A=0xFFFFFFFF, B=1.
  - Response: ovf=0, cout=1.

Source files
------------

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin sharing of one external N-bit adder among NREQ requesters.
// Defining ADDER_ARBITER_OVF_EN adds a registered signed-overflow output ovf.
module adder_arbiter #(
   parameter int N    = 32,
   parameter int NREQ = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ*N-1:0] a_bus,
   input  logic [NREQ*N-1:0] b_bus,
   input  logic [NREQ-1:0]   cin_bus,
   output logic [NREQ-1:0]   grant,
   output logic              busy,
   output logic              done,
   output logic [N-1:0]      sum,
   output logic              cout,
   output logic [N-1:0]      add_a,
   output logic [N-1:0]      add_b,
   output logic              add_cin,
   input  logic [N-1:0]      add_s,
   input  logic              add_cout
`ifdef ADDER_ARBITER_OVF_EN
   ,output logic             ovf
`endif
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
   state_t state, state_nx;
   logic [PW-1:0] ptr, win;
   logic [NREQ-1:0] elig, win_oh;
   logic any;
   // round-robin search starting just after the last winner; the owner is masked in DONE
   always_comb begin
      elig = (state == IDLE) ? req : (state == DONE) ? (req & ~grant) : '0;
      win = ptr;
      win_oh = '0;
      any = 1'b0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!any && elig[(int'(ptr) + k) % NREQ]) begin
            any = 1'b1;
            win = PW'((int'(ptr) + k) % NREQ);
            win_oh[(int'(ptr) + k) % NREQ] = 1'b1;
         end
      end
   end
   // ADD always lasts one cycle; IDLE and DONE both move to ADD when someone is eligible
   always_comb begin
      state_nx = (state == ADD) ? DONE : any ? ADD : IDLE;
   end
   // state register
   always_ff @(posedge clk) begin
      if (!resetn) state <= IDLE;
      else state <= state_nx;
   end
   // operand latch on arbitration, result capture in ADD, grant release when returning to IDLE
   always_ff @(posedge clk) begin
      if (!resetn) begin
         ptr <= PW'(NREQ - 1);
         grant <= '0;
         done <= 1'b0;
         sum <= '0;
         cout <= 1'b0;
         add_a <= '0;
         add_b <= '0;
         add_cin <= 1'b0;
      end else begin
         done <= (state == ADD);
         if (state == ADD) begin
            sum <= add_s;
            cout <= add_cout;
         end
         if (any) begin
            ptr <= win;
            grant <= win_oh;
            add_a <= a_bus[int'(win)*N +: N];
            add_b <= b_bus[int'(win)*N +: N];
            add_cin <= cin_bus[win];
         end else if (state == DONE) begin
            grant <= '0;
         end
      end
   end
   assign busy = (state != IDLE);
`ifdef ADDER_ARBITER_OVF_EN
   // signed overflow of the shared adder, captured alongside sum
   always_ff @(posedge clk) begin
      if (!resetn) ovf <= 1'b0;
      else if (state == ADD) ovf <= (add_a[N-1] == add_b[N-1]) && (add_s[N-1] != add_a[N-1]);
   end
`endif
endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors plus randomized traffic against a timing-level reference model.
module tb_adder_arbiter;
   localparam int N = 32;
   localparam int NREQ = 4;
   logic clk = 1'b0;
   logic resetn = 1'b0;
   logic [NREQ-1:0] req = '0;
   logic [NREQ-1:0] cin_bus = '0;
   logic [NREQ*N-1:0] a_bus = '0;
   logic [NREQ*N-1:0] b_bus = '0;
   logic [NREQ-1:0] grant;
   logic busy, done, cout, add_cin, add_cout;
   logic [N-1:0] sum, add_a, add_b, add_s;
`ifdef ADDER_ARBITER_OVF_EN
   logic ovf;
   logic m_ovf, r_ovf;
`endif
   int errors = 0;
   int checks = 0;
   typedef struct {
      int idx;
      logic [N-1:0] a;
      logic [N-1:0] b;
      logic cin;
      logic [N-1:0] s;
      logic co;
      logic ov;
   } vec_t;
   vec_t vt[5];
   int order[5] = '{1, 2, 4, 8, 1};
   int n_done, last_done, sel, last, owner, w, t, tt;
   logic [NREQ-1:0] elig;
   logic [N:0] res;
   logic [N-1:0] m_sum, ea, eb;
   logic m_cout, ecin;

   always #5 clk = ~clk;

   // stand-in for the external shared adder
   assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_cin};

   adder_arbiter #(.N(N), .NREQ(NREQ)) dut (
      .clk(clk), .resetn(resetn), .req(req), .a_bus(a_bus), .b_bus(b_bus), .cin_bus(cin_bus),
      .grant(grant), .busy(busy), .done(done), .sum(sum), .cout(cout),
      .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_s(add_s), .add_cout(add_cout)
`ifdef ADDER_ARBITER_OVF_EN
      , .ovf(ovf)
`endif
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset;
      resetn = 1'b0;
      req = '0;
      tick;
      resetn = 1'b1;
   endtask

   task automatic set_op(input int i, input logic [N-1:0] a, input logic [N-1:0] b, input logic c);
      a_bus[i*N +: N] = a;
      b_bus[i*N +: N] = b;
      cin_bus[i] = c;
   endtask

   function automatic int pick(input logic [NREQ-1:0] e, input int from);
      for (int k = 1; k <= NREQ; k++)
         if (e[(from + k) % NREQ]) return (from + k) % NREQ;
      return -1;
   endfunction

   initial begin
      vt[0] = '{0, 32'd5, 32'd7, 1'b0, 32'd12, 1'b0, 1'b0};
      vt[1] = '{2, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h0, 1'b1, 1'b0};
      vt[2] = '{2, 32'hFFFFFFFF, 32'h0, 1'b1, 32'h0, 1'b1, 1'b0};
      vt[3] = '{3, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1'b0, 1'b1};
      vt[4] = '{1, 32'h12345678, 32'h11111111, 1'b1, 32'h2345678A, 1'b0, 1'b0};

      do_reset;
      chk("reset_grant", grant, 0);
      chk("reset_done", done, 0);
      chk("reset_busy", busy, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", cout, 0);
      chk("reset_add_a", add_a, 0);
      chk("reset_add_b", add_b, 0);
      chk("reset_add_cin", add_cin, 0);

      for (int v = 0; v < 5; v++) begin
         do_reset;
         set_op(vt[v].idx, vt[v].a, vt[v].b, vt[v].cin);
         req = 4'b1 << vt[v].idx;
         tick;
         chk("vec_grant_add", grant, 4'b1 << vt[v].idx);
         chk("vec_done_add", done, 0);
         chk("vec_busy_add", busy, 1);
         chk("vec_add_a", add_a, vt[v].a);
         tick;
         chk("vec_done", done, 1);
         chk("vec_grant_done", grant, 4'b1 << vt[v].idx);
         chk("vec_sum", sum, vt[v].s);
         chk("vec_cout", cout, vt[v].co);
`ifdef ADDER_ARBITER_OVF_EN
         chk("vec_ovf", ovf, vt[v].ov);
`endif
         req = '0;
         tick;
         chk("vec_done_after", done, 0);
         chk("vec_grant_idle", grant, 0);
         chk("vec_busy_idle", busy, 0);
         chk("vec_sum_hold", sum, vt[v].s);
      end

      do_reset;
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10, 1'b0);
      req = 4'hF;
      n_done = 0;
      last_done = 0;
      for (int c = 1; c <= 12; c++) begin
         tick;
         if (done && n_done < 5) begin
            chk("cont_grant", grant, order[n_done]);
            chk("cont_sum", sum, 11 + (n_done % 4));
            chk("cont_gap", c - last_done, 2);
            last_done = c;
            n_done++;
         end
      end
      chk("cont_count", n_done, 5);

      do_reset;
      set_op(1, 3, 4, 1'b0);
      req = 4'b0010;
      for (int c = 1; c <= 9; c++) begin
         tick;
         chk("lone_done", done, (c % 3) == 2);
         chk("lone_grant", grant, ((c % 3) == 0) ? 4'b0000 : 4'b0010);
         chk("lone_busy", busy, (c % 3) != 0);
      end
      chk("lone_sum", sum, 7);

      do_reset;
      for (int i = 0; i < NREQ; i++) set_op(i, i + 1, 10, 1'b0);
      req = 4'hF;
      tick;
      tick;
      tick;
      chk("rst_pre_grant", grant, 4'b0010);
      resetn = 1'b0;
      tick;
      chk("rst_done", done, 0);
      chk("rst_grant", grant, 0);
      chk("rst_sum", sum, 0);
      chk("rst_busy", busy, 0);
      resetn = 1'b1;
      tick;
      chk("rst_first_grant", grant, 4'b0001);
      tick;
      chk("rst_first_sum", sum, 11);

      do_reset;
      sel = -100;
      last = NREQ - 1;
      owner = 0;
      m_sum = '0;
      m_cout = 1'b0;
      res = '0;
`ifdef ADDER_ARBITER_OVF_EN
      m_ovf = 1'b0;
      r_ovf = 1'b0;
`endif
      for (int e = 0; e < 2000; e++) begin
         req = NREQ'($urandom_range(0, 15));
         for (int i = 0; i < NREQ; i++)
            set_op(i, ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom, $urandom, 1'($urandom));
         t = e - sel;
         elig = (t == 1) ? '0 : (t == 2) ? (req & ~(4'b1 << owner)) : req;
         w = pick(elig, last);
         if (w >= 0) begin
            sel = e;
            last = w;
            owner = w;
            ea = a_bus[w*N +: N];
            eb = b_bus[w*N +: N];
            ecin = cin_bus[w];
            res = {1'b0, ea} + {1'b0, eb} + {{N{1'b0}}, ecin};
`ifdef ADDER_ARBITER_OVF_EN
            r_ovf = (ea[N-1] == eb[N-1]) && (res[N-1] != ea[N-1]);
`endif
         end
         tick;
         tt = e - sel;
         if (tt == 1) begin
            m_sum = res[N-1:0];
            m_cout = res[N];
`ifdef ADDER_ARBITER_OVF_EN
            m_ovf = r_ovf;
`endif
         end
         chk("rnd_grant", grant, (tt <= 1) ? (4'b1 << owner) : 4'b0);
         chk("rnd_done", done, tt == 1);
         chk("rnd_busy", busy, tt <= 1);
         chk("rnd_sum", sum, m_sum);
         chk("rnd_cout", cout, m_cout);
`ifdef ADDER_ARBITER_OVF_EN
         chk("rnd_ovf", ovf, m_ovf);
`endif
         if (tt == 0) begin
            chk("rnd_add_a", add_a, ea);
            chk("rnd_add_b", add_b, eb);
            chk("rnd_add_cin", add_cin, ecin);
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
